// File: rtl/tff_counter.sv
// tff_counter: up/down mod-MODULUS counter built from per-bit T flip-flop stages
// Ports: clk, rst (async, active-high), clr (sync clear), load/din (clamped parallel load),
//        en/up (count enable/direction), q (count), tc (terminal-count pulse), qg (Gray copy of q).
// Define TFF_COUNTER_GRAY_EN to build the registered Gray output; otherwise qg is tied to 0.
module tff_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic [WIDTH-1:0] qg
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    logic [WIDTH-1:0] cnt_q, cnt_d, nxt, step, t;
    logic             tc_q, tc_d, at_top, at_bot;
    always_comb begin
        at_top = cnt_q == MAX;
        at_bot = cnt_q == '0;
        step   = up ? (at_top ? (SATURATE != 0 ? cnt_q : '0) : cnt_q + 1'b1)
                    : (at_bot ? (SATURATE != 0 ? cnt_q : MAX) : cnt_q - 1'b1);
        nxt    = clr ? '0 : load ? (din > MAX ? MAX : din) : en ? step : cnt_q;
        // each stage toggles exactly where the target differs from the current count
        t      = cnt_q ^ nxt;
        cnt_d  = cnt_q ^ t;
        tc_d   = !clr && !load && en && (up ? at_top : at_bot);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end
    assign q  = cnt_q;
    assign tc = tc_q;
`ifdef TFF_COUNTER_GRAY_EN
    logic [WIDTH-1:0] qg_q, qg_d;
    always_comb qg_d = nxt ^ (nxt >> 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) qg_q <= '0;
        else qg_q <= qg_d;
    end
    assign qg = qg_q;
`else
    assign qg = '0;
`endif
endmodule

// File: tb/tb_tff_counter.sv
// tb_tff_counter: directed bench for tff_counter with a per-cycle arithmetic reference model
module tb_tff_counter;
    logic       clk = 0, rst = 1, clr = 0, load = 0, en = 0, up = 0;
    logic [3:0] din = 0;
    logic [3:0] q_a [3];
    logic [3:0] qg_a [3];
    logic       tc_a [3];
    int         n_cmp = 0, n_bad = 0;
    int         mods [3] = '{10, 10, 16};
    int         sats [3] = '{0, 1, 0};
    int         mq [3];
    int         mtc [3];
    int         gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) d0 (.clk(clk), .rst(rst), .clr(clr), .load(load),
        .din(din), .en(en), .up(up), .q(q_a[0]), .tc(tc_a[0]), .qg(qg_a[0]));
    tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) d1 (.clk(clk), .rst(rst), .clr(clr), .load(load),
        .din(din), .en(en), .up(up), .q(q_a[1]), .tc(tc_a[1]), .qg(qg_a[1]));
    tff_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) d2 (.clk(clk), .rst(rst), .clr(clr), .load(load),
        .din(din), .en(en), .up(up), .q(q_a[2]), .tc(tc_a[2]), .qg(qg_a[2]));

    function automatic int model_q(int m, int sat, int cur);
        if (clr) return 0;
        if (load) return (int'(din) >= m) ? m - 1 : int'(din);
        if (!en) return cur;
        if (up) return (cur == m - 1) ? (sat != 0 ? cur : 0) : cur + 1;
        return (cur == 0) ? (sat != 0 ? cur : m - 1) : cur - 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mq[k]  <= 0;
                mtc[k] <= 0;
            end else begin
                mq[k]  <= model_q(mods[k], sats[k], mq[k]);
                mtc[k] <= (!clr && !load && en && (up ? mq[k] == mods[k] - 1 : mq[k] == 0)) ? 1 : 0;
            end
        end
    end

    task automatic chk(input string n, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int model_qg(int v);
`ifdef TFF_COUNTER_GRAY_EN
        return v ^ (v >> 1);
`else
        return 0 * v;
`endif
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_q[%0d]", k), int'(q_a[k]), mq[k]);
            chk($sformatf("model_tc[%0d]", k), int'(tc_a[k]), mtc[k]);
            chk($sformatf("model_qg[%0d]", k), int'(qg_a[k]), model_qg(mq[k]));
        end
    end

    task automatic cyc(input logic c, input logic l, input logic e, input logic u, input logic [3:0] d);
        clr = c; load = l; en = e; up = u; din = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] prev;
        #12 rst = 0;
        chk("reset_q", int'(q_a[0]), 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 1, 0);
            chk("wrap_up_q", int'(q_a[0]), (i + 1) % 10);
            chk("wrap_up_tc", int'(tc_a[0]), i == 9 ? 1 : 0);
        end
        chk("sat_top_q", int'(q_a[1]), 9);
        chk("sat_top_tc", int'(tc_a[1]), 1);
        chk("mod16_q", int'(q_a[2]), 10);
        cyc(1, 0, 0, 0, 0);
        chk("clr_q", int'(q_a[0]), 0);
        chk("clr_tc", int'(tc_a[0]), 0);
        cyc(0, 0, 1, 0, 0);
        chk("wrap_down_q", int'(q_a[0]), 9);
        chk("wrap_down_tc", int'(tc_a[0]), 1);
        chk("sat_bot_q", int'(q_a[1]), 0);
        chk("sat_bot_tc", int'(tc_a[1]), 1);
        chk("down16_q", int'(q_a[2]), 15);
        cyc(0, 1, 0, 0, 9);
        chk("load9_q", int'(q_a[1]), 9);
        chk("load9_tc", int'(tc_a[1]), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 0);
            chk("sat_hold_q", int'(q_a[1]), 9);
            chk("sat_hold_tc", int'(tc_a[1]), 1);
            chk("wrap_after_load_q", int'(q_a[0]), i);
        end
        cyc(1, 1, 1, 1, 5);
        chk("prio_clr_q", int'(q_a[0]), 0);
        cyc(0, 1, 0, 0, 13);
        chk("clamp_q", int'(q_a[0]), 9);
        chk("clamp_tc", int'(tc_a[0]), 0);
        chk("noclamp16_q", int'(q_a[2]), 13);
        cyc(0, 1, 1, 1, 4);
        chk("prio_load_q", int'(q_a[0]), 4);
        cyc(0, 1, 0, 0, 6);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("hold_q", int'(q_a[0]), 6);
            chk("hold_tc", int'(tc_a[0]), 0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, (i % 2) == 0, 0);
            chk("dir_q", int'(q_a[0]), (i % 2) == 0 ? 7 : 6);
        end
        cyc(0, 1, 0, 0, 7);
        chk("pre_rst_q", int'(q_a[0]), 7);
        #1 rst = 1;
        #1;
        chk("async_rst_q", int'(q_a[0]), 0);
        chk("async_rst_tc", int'(tc_a[0]), 0);
        chk("async_rst_qg", int'(qg_a[0]), 0);
        clr = 0; load = 0; en = 1; up = 1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_hold_q", int'(q_a[0]), 0);
        rst = 0;
        cyc(0, 0, 1, 1, 0);
        chk("post_rst_q", int'(q_a[0]), 1);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            prev = qg_a[2];
            cyc(0, 0, 1, 1, 0);
`ifdef TFF_COUNTER_GRAY_EN
            chk("gray_onebit", $countones(prev ^ qg_a[2]), 1);
            chk("gray_value", int'(qg_a[2]), gray_tab[(i + 1) % 16]);
`else
            chk("gray_off", int'(qg_a[2]), 0);
`endif
        end
        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
